readout_serializer: RTL and testbench
=====================================

Name: readout_serializer

Overview:
- Downstream consumer of the capture-memory read port.
- After a capture completes, it walks memory backwards one read step at a time by pulsing rd_ready.
- It takes each returned 32-bit word with its byte-lane keep mask and emits only the kept bytes, LSB lane first, as a byte stream toward the host transmitter (UART/SPI).
- It stops after a programmed number of read steps.

Parameters:
- MDW, 32, read data width; fixed at 4 byte lanes.
- CNT_W, 16, width of the read-step counter.
- RD_LAT, 2, cycles from an rd_ready pulse until rd_data/rd_keep reflect the new address (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  single-cycle pulse: begin readout; ignored unless idle
- read_count  in  CNT_W  number of read steps (words) to emit; sampled on start
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- done  out  1  single-cycle pulse when readout completes
- rd_ready  out  1  single-cycle pulse: memory steps to the previous word
- rd_valid  in  1  memory word has at least one kept lane
- rd_keep  in  4  byte-lane valid mask for rd_data
- rd_data  in  MDW  memory read word
- tx_valid  out  1  byte available on tx_data
- tx_ready  in  1  transmitter accepts the byte when tx_valid & tx_ready
- tx_data  out  8  output byte

Behaviour:
- Reset values: busy=0, done=0, rd_ready=0, tx_valid=0, tx_data=0. FSM returns to IDLE and counters clear. rst mid-readout aborts immediately with no done pulse.
- FSM states: IDLE, LOAD, SHIFT, STEP, WAIT.
- IDLE:
  - start=1 latches remaining=read_count.
  - If read_count==0: pulse done the next cycle and stay IDLE; busy stays 0.
  - Otherwise go to LOAD. The word at the current address is already presented, so no initial rd_ready.
- LOAD: capture rd_data into the shift word and rd_keep into lane_mask.
  - If rd_valid==0 or rd_keep==0, emit no bytes and go to STEP.
  - Otherwise go to SHIFT.
- SHIFT:
  - tx_data = lowest set lane of lane_mask; tx_valid=1.
  - On tx_valid&tx_ready, clear that lane bit.
  - When the last bit clears, go to STEP.
  - tx_data/tx_valid hold stable while tx_ready=0.
  - One byte per cycle maximum; back-to-back bytes with tx_ready held high.
- STEP: decrement remaining.
  - If remaining becomes 0: go to IDLE, pulse done, drop busy the same cycle. No rd_ready is issued after the final word.
  - Else: pulse rd_ready for one cycle, load wait counter with RD_LAT, go to WAIT.
- WAIT: count down; on reaching 0 go to LOAD. rd_keep and rd_data are sampled together.
- Byte order:
  - Within a word: lane 0 (bits 7:0) first, lane 3 last, skipping lanes with keep=0.
  - Across words: memory order as produced by the rd_ready stepping (newest sample first).
- Throughput: word with k kept lanes costs k + 2 + RD_LAT cycles with tx_ready=1.
- start while busy is ignored. rd_ready is never asserted outside STEP.

Optional Feature:
- Macro READOUT_CHECKSUM_EN.
- When defined: a CHECKSUM state follows the final STEP. It emits one extra byte equal to the XOR of all bytes sent in this readout (register cleared on start), using the same tx handshake. done pulses after that byte is accepted.
- When undefined: no checksum state; done pulses in the final STEP.

Decomposition:
- Shared package: FSM state encoding, lane count constant (4), and RD_LAT default, shared with the memory interface.
- One natural sub-module: readout_lane_picker. It is combinational and returns the lowest set lane index plus a one-hot clear mask from a 4-bit mask; it is reused wherever keep masks are walked.

Test Plan:
- read_count=2, keep=4'hF, words 0x44332211 then 0x88776655, tx_ready=1 → bytes 11,22,33,44,55,66,77,88; exactly one rd_ready pulse; done once; busy low after.
- 8-bit mode: keep=0001/0010/0100/1000 per word, read_count=4 → one byte per word, from lanes 0,1,2,3 respectively; 3 rd_ready pulses spaced RD_LAT+3 cycles.
- keep=4'h7, word 0xAABBCCDD → DD,CC,BB emitted; AA never appears.
- tx_ready toggling 1,0,0,1 during SHIFT → tx_data constant while stalled; no byte duplicated or lost.
- read_count=0 → done pulse one cycle after start; no rd_ready, no tx_valid; start while busy has no effect.
- rst asserted mid-SHIFT → next cycle all outputs 0, state IDLE, no done. With READOUT_CHECKSUM_EN and bytes 11,22,33,44: trailing byte 0x44 (11^22^33^44).

Source files
------------

// File: rtl/readout_serializer_pkg.sv
// Shared definitions for the capture-memory readout path: FSM encoding,
// byte-lane geometry, default read latency and a lane byte-select helper.
package readout_serializer_pkg;

  localparam int unsigned LANES          = 4;
  localparam int unsigned LANE_W         = 8;
  localparam int unsigned LANE_IDX_W     = 2;
  localparam int unsigned MDW_DEFAULT    = LANES * LANE_W;
  localparam int unsigned CNT_W_DEFAULT  = 16;
  localparam int unsigned RD_LAT_DEFAULT = 2;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_SHIFT    = 3'd2;
  localparam logic [2:0] S_STEP     = 3'd3;
  localparam logic [2:0] S_WAIT     = 3'd4;
  localparam logic [2:0] S_CHECKSUM = 3'd5;

  // Byte carried by lane idx of a memory word
  function automatic logic [LANE_W-1:0] lane_byte(input logic [MDW_DEFAULT-1:0] word,
                                                  input logic [LANE_IDX_W-1:0] idx);
    return word[{idx, 3'b000} +: LANE_W];
  endfunction

endpackage

// File: rtl/readout_lane_picker.sv
// Lowest-set-lane finder for a 4-bit keep mask: lane index plus one-hot
// mask of that lane (all zeros when the mask is empty).
module readout_lane_picker
  import readout_serializer_pkg::*;
(
  input  logic [LANES-1:0]      mask_i,
  output logic [LANE_IDX_W-1:0] idx_o,
  output logic [LANES-1:0]      clr_o
);

  always_comb begin
    idx_o = '0;
    clr_o = '0;
    casez (mask_i)
      4'b???1: begin idx_o = 2'd0; clr_o = 4'b0001; end
      4'b??10: begin idx_o = 2'd1; clr_o = 4'b0010; end
      4'b?100: begin idx_o = 2'd2; clr_o = 4'b0100; end
      4'b1000: begin idx_o = 2'd3; clr_o = 4'b1000; end
      default: ;
    endcase
  end

endmodule

// File: rtl/readout_serializer.sv
// Walks capture memory backwards and streams the kept bytes of each word,
// lane 0 first. Define READOUT_CHECKSUM_EN to append an XOR checksum byte.
module readout_serializer
  import readout_serializer_pkg::*;
#(
  parameter int unsigned MDW    = MDW_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT,
  parameter int unsigned RD_LAT = RD_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] read_count,
  output logic             busy,
  output logic             done,
  output logic             rd_ready,
  input  logic             rd_valid,
  input  logic [LANES-1:0] rd_keep,
  input  logic [MDW-1:0]   rd_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data
);

  localparam int unsigned WAIT_W = $clog2(RD_LAT + 1);

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [MDW-1:0]        word_q, word_d;
  logic [LANES-1:0]      mask_q, mask_d;
  logic [7:0]            csum_q, csum_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_ready_q, rd_ready_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [LANE_IDX_W-1:0] cur_idx, nxt_idx;
  logic [LANES-1:0]      cur_clr, nxt_clr;
  logic                  fire;
  logic                  last_word;

  assign fire      = tx_valid_q & tx_ready;
  assign last_word = (remaining_q == CNT_W'(1));

  readout_lane_picker u_cur_pick (.mask_i(mask_q), .idx_o(cur_idx), .clr_o(cur_clr));
  readout_lane_picker u_nxt_pick (.mask_i(mask_d), .idx_o(nxt_idx), .clr_o(nxt_clr));

  // Word/lane-mask update kept apart so the next-lane picker sees it without a loop
  always_comb begin
    word_d = word_q;
    mask_d = mask_q;
    if (state_q == S_LOAD) begin
      word_d = rd_data;
      mask_d = rd_valid ? rd_keep : '0;
    end else if (state_q == S_SHIFT && fire) begin
      mask_d = mask_q & ~cur_clr;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    csum_d      = csum_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_ready_d  = 1'b0;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = read_count;
          csum_d      = '0;
          if (read_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            busy_d  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (|nxt_clr) begin
          state_d    = S_SHIFT;
          tx_valid_d = 1'b1;
          tx_data_d  = lane_byte(word_d, nxt_idx);
        end else begin
          state_d    = S_STEP;
          rd_ready_d = !last_word;
        end
      end
      S_SHIFT: begin
        if (fire) begin
          csum_d = csum_q ^ lane_byte(word_q, cur_idx);
          if (|nxt_clr) begin
            tx_data_d = lane_byte(word_d, nxt_idx);
          end else begin
            tx_valid_d = 1'b0;
            state_d    = S_STEP;
            rd_ready_d = !last_word;
          end
        end
      end
      S_STEP: begin
        remaining_d = remaining_q - CNT_W'(1);
        if (last_word) begin
`ifdef READOUT_CHECKSUM_EN
          state_d    = S_CHECKSUM;
          tx_valid_d = 1'b1;
          tx_data_d  = csum_q;
`else
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`endif
        end else begin
          state_d = S_WAIT;
          wait_d  = WAIT_W'(RD_LAT);
        end
      end
      S_WAIT: begin
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q <= WAIT_W'(1)) begin
          state_d = S_LOAD;
        end
      end
`ifdef READOUT_CHECKSUM_EN
      S_CHECKSUM: begin
        if (fire) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
          done_d     = 1'b1;
          busy_d     = 1'b0;
        end
      end
`endif
      default: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      wait_q      <= '0;
      word_q      <= '0;
      mask_q      <= '0;
      csum_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      word_q      <= word_d;
      mask_q      <= mask_d;
      csum_q      <= csum_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_ready_q  <= rd_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_ready = rd_ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_readout_serializer.sv
// Scoreboard bench for readout_serializer: directed memory images with
// hand-computed byte streams, checked by an independent negedge monitor.
module tb_readout_serializer;
  import readout_serializer_pkg::*;

  localparam int unsigned CNT_W = CNT_W_DEFAULT;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] read_count;
  logic             busy, done, rd_ready, rd_valid, tx_valid, tx_ready;
  logic [3:0]       rd_keep;
  logic [31:0]      rd_data;
  logic [7:0]       tx_data;

  readout_serializer dut (
    .clk(clk), .rst(rst), .start(start), .read_count(read_count),
    .busy(busy), .done(done), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_keep(rd_keep), .rd_data(rd_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  // Memory model: a step requested by rd_ready is visible RD_LAT cycles later
  logic [31:0] mem_data [16];
  logic [3:0]  mem_keep [16];
  logic [3:0]  mem_idx;
  logic [7:0]  rd_pipe;
  logic [8:0]  rd_hist;
  logic        mem_clr;

  assign rd_data = mem_data[mem_idx];
  assign rd_keep = mem_keep[mem_idx];
  assign rd_valid = |rd_keep;
  assign rd_hist = {rd_pipe, rd_ready};

  always @(posedge clk) begin
    if (mem_clr) begin
      mem_idx <= '0;
      rd_pipe <= '0;
    end else begin
      rd_pipe <= {rd_pipe[6:0], rd_ready};
      if (rd_hist[RD_LAT_DEFAULT-1]) mem_idx <= mem_idx + 4'd1;
    end
  end

  int          checks_total  = 0;
  int          checks_passed = 0;
  logic [7:0]  exp_q [$];
  int          rd_times [$];
  int          cycle = 0;
  int          done_cnt = 0;
  int          rd_ready_cnt = 0;
  logic        stall_q = 1'b0;
  logic [7:0]  stall_data = '0;
  logic [7:0]  csum_acc = '0;
  bit          tx_pat [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: byte scoreboard, stall stability, done/rd_ready bookkeeping
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid_hold", 32'(tx_valid), 32'd1);
        check("stall_data_hold", 32'(tx_data), 32'(stall_data));
      end
      if (rd_ready) begin
        rd_ready_cnt++;
        rd_times.push_back(cycle);
      end
      if (done) done_cnt++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks_total++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte", tx_data);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      stall_q    = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  task automatic push(input logic [7:0] b);
    exp_q.push_back(b);
    csum_acc = csum_acc ^ b;
  endtask

  task automatic mem_reset();
    mem_clr = 1'b1;
    @(posedge clk); #1;
    mem_clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_data[i] = '0;
      mem_keep[i] = '0;
    end
  endtask

  task automatic run_readout(input int n, input bit toggle, input int restart_at, input int exp_rr);
    int base_done;
    int base_rr;
`ifdef READOUT_CHECKSUM_EN
    if (n > 0) exp_q.push_back(csum_acc);
`endif
    base_done = done_cnt;
    base_rr   = rd_ready_cnt;
    rd_times.delete();
    read_count = CNT_W'(n);
    start = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      start = (c == restart_at);
      if (start) read_count = CNT_W'(3);
      if (toggle) tx_ready = tx_pat[c % 4];
      if (done_cnt != base_done) break;
    end
    start    = 1'b0;
    tx_ready = 1'b1;
    check("done_count", 32'(done_cnt - base_done), 32'd1);
    check("done_single_cycle", 32'(done), 32'd0);
    check("rd_ready_count", 32'(rd_ready_cnt - base_rr), 32'(exp_rr));
    check("busy_after_done", 32'(busy), 32'd0);
    check("bytes_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    csum_acc = '0;
  endtask

  initial begin
    int base_done;
    tx_pat[0] = 1'b1; tx_pat[1] = 1'b0; tx_pat[2] = 1'b0; tx_pat[3] = 1'b1;
    rst = 1'b1; start = 1'b0; read_count = '0; tx_ready = 1'b1; mem_clr = 1'b1;
    mem_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_ready", 32'(rd_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two full words
    mem_reset();
    mem_data[0] = 32'h44332211; mem_keep[0] = 4'hF;
    mem_data[1] = 32'h88776655; mem_keep[1] = 4'hF;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    run_readout(2, 1'b0, -1, 1);

    // One lane per word, walking lanes 0..3
    mem_reset();
    mem_data[0] = 32'h13121110; mem_keep[0] = 4'b0001;
    mem_data[1] = 32'h23222120; mem_keep[1] = 4'b0010;
    mem_data[2] = 32'h33323130; mem_keep[2] = 4'b0100;
    mem_data[3] = 32'h43424140; mem_keep[3] = 4'b1000;
    push(8'h10); push(8'h21); push(8'h32); push(8'h43);
    run_readout(4, 1'b0, -1, 3);
    if (rd_times.size() == 3) begin
      check("rd_ready_gap0", 32'(rd_times[1] - rd_times[0]), 32'(RD_LAT_DEFAULT + 3));
      check("rd_ready_gap1", 32'(rd_times[2] - rd_times[1]), 32'(RD_LAT_DEFAULT + 3));
    end

    // Upper lane masked off
    mem_reset();
    mem_data[0] = 32'hAABBCCDD; mem_keep[0] = 4'h7;
    push(8'hDD); push(8'hCC); push(8'hBB);
    run_readout(1, 1'b0, -1, 0);

    // Backpressure 1,0,0,1
    mem_reset();
    mem_data[0] = 32'h44332211; mem_keep[0] = 4'hF;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    run_readout(1, 1'b1, -1, 0);

    // Zero-length readout
    mem_reset();
    base_done = done_cnt;
    read_count = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_tx_valid", 32'(tx_valid), 32'd0);
    check("zero_rd_ready", 32'(rd_ready), 32'd0);
    @(negedge clk);
    check("zero_done_pulse", 32'(done_cnt - base_done), 32'd1);
    @(posedge clk); #1;

    // Start while busy must be ignored
    mem_reset();
    mem_data[0] = 32'h0D0C0B0A; mem_keep[0] = 4'hF;
    push(8'h0A); push(8'h0B); push(8'h0C); push(8'h0D);
    run_readout(1, 1'b0, 3, 0);

    // Reset in the middle of SHIFT
    mem_reset();
    mem_data[0] = 32'h55667788; mem_keep[0] = 4'hF;
    base_done = done_cnt;
    tx_ready = 1'b0;
    read_count = CNT_W'(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && !tx_valid; c++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rd_ready", 32'(rd_ready), 32'd0);
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    tx_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
